// File: rtl/gf2m_pow_ctrl.sv
// Square-and-multiply sequencer for GF(2^m) exponentiation.
// Drives an external multiplier; result = base^exp mod f(x).
module gf2m_pow_ctrl #(
  parameter int WIDTH = 107,
  parameter int EXP_W = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [EXP_W-1:0] exp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_op_a,
  output logic [WIDTH-1:0] mul_op_b,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_op_c
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SQ,
    SQ_W,
    MUL,
    MUL_W,
    FIN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] base_r_q, base_r_d;
  logic [EXP_W-1:0] exp_r_q, exp_r_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      base_r_q <= '0;
      exp_r_q  <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      base_r_q <= base_r_d;
      exp_r_q  <= exp_r_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    base_r_d = base_r_q;
    exp_r_d  = exp_r_q;
    idx_d    = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_r_d = base;
          exp_r_d  = exp;
          acc_d    = WIDTH'(1);
          idx_d    = IDX_W'(EXP_W - 1);
          state_d  = SQ;
        end
      end
      SQ: state_d = SQ_W;
      SQ_W: begin
        if (mul_done) begin
          acc_d = mul_op_c;
          if (exp_r_q[idx_q]) begin
            state_d = MUL;
          end else if (idx_q == '0) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = SQ;
          end
        end
      end
      MUL: state_d = MUL_W;
      MUL_W: begin
        if (mul_done) begin
          acc_d = mul_op_c;
          if (idx_q == '0) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = SQ;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: one mul_start per issue state, glitch-free
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign mul_start = (state_q == SQ) || (state_q == MUL);
  assign mul_op_a  = acc_q;
  assign mul_op_b  = ((state_q == MUL) || (state_q == MUL_W)) ? base_r_q : acc_q;
  assign result    = acc_q;

endmodule

// File: tb/tb_gf2m_pow_ctrl.sv
// Scoreboarded random bench for gf2m_pow_ctrl with a
// behavioural digit-serial multiplier stand-in (latency L).
module tb_gf2m_pow_ctrl;

  localparam int W = 107;
  localparam int E = 16;
  localparam int L = 8;
  localparam logic [W-1:0] RED = W'(12'h291);

  logic         clk = 1'b0;
  logic         rst_b;
  logic         start;
  logic [W-1:0] base;
  logic [E-1:0] exp;
  logic         busy, done, mul_start;
  logic [W-1:0] result, mul_op_a, mul_op_b, mul_op_c;
  logic         mul_done;

  logic         m_pend, m_done;
  logic [3:0]   m_cnt;
  logic [W-1:0] m_prod;
  logic         stray;
  logic [W-1:0] stray_val;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int n_ms = 0;

  typedef struct {
    logic [W-1:0] res;
    int           ops;
    int           scyc;
  } exp_t;
  exp_t sbq[$];

  gf2m_pow_ctrl #(.WIDTH(W), .EXP_W(E)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .start    (start),
    .base     (base),
    .exp      (exp),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .mul_start(mul_start),
    .mul_op_a (mul_op_a),
    .mul_op_b (mul_op_b),
    .mul_done (mul_done),
    .mul_op_c (mul_op_c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] gfmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = W - 1; i >= 0; i--) begin
      r = r[W-1] ? ((r << 1) ^ RED) : (r << 1);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  // Right-to-left binary powering, independent of the DUT's order
  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] b, input logic [E-1:0] e);
    logic [W-1:0] r, p;
    r = W'(1);
    p = b;
    for (int i = 0; i < E; i++) begin
      if (e[i]) r = gfmul(r, p);
      p = gfmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_el();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_pend <= 1'b0;
      m_cnt  <= '0;
      m_done <= 1'b0;
      m_prod <= '0;
    end else begin
      m_done <= 1'b0;
      if (mul_start) begin
        m_pend <= 1'b1;
        m_cnt  <= 4'(L - 1);
        m_prod <= gfmul(mul_op_a, mul_op_b);
      end else if (m_pend) begin
        if (m_cnt == 4'd1) begin
          m_done <= 1'b1;
          m_pend <= 1'b0;
        end
        m_cnt <= m_cnt - 4'd1;
      end
    end
  end

  assign mul_done = m_done | stray;
  assign mul_op_c = m_done ? m_prod : stray_val;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic chki(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_b) begin
      n_ms = 0;
    end else begin
      if (mul_start) begin
        n_ms++;
        chki("no_overlap", int'(m_pend), 0);
      end
      if (done) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no done");
        end else begin
          e = sbq.pop_front();
          chk("result", result, e.res);
          chki("done_cycle", cyc, e.scyc + 1 + e.ops * (L + 1));
          chki("mul_starts", n_ms, e.ops);
          chki("busy_fin", int'(busy), 1);
        end
        n_ms = 0;
      end
    end
  end

  task automatic run_op(input logic [W-1:0] b, input logic [E-1:0] e, input int inj);
    int  s;
    bit  fin;
    @(negedge clk);
    start = 1'b1;
    base  = b;
    exp   = e;
    s     = cyc;
    sbq.push_back('{res: ref_pow(b, e), ops: E + $countones(e), scyc: s});
    fin = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start = (inj > 0) && (cyc == s + inj);
      base  = rnd_el();
      exp   = E'($urandom);
      #1;
      if (sbq.size() == 0) begin
        fin = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!fin) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got no done expected done for exp=%0h", e);
      sbq.delete();
    end
    @(posedge clk);
    #1;
    chki("busy_after", int'(busy), 0);
  endtask

  initial begin
    int s;
    logic [W-1:0] b;
    logic [E-1:0] e;
    rst_b     = 1'b0;
    start     = 1'b0;
    base      = '0;
    exp       = '0;
    stray     = 1'b0;
    stray_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", result, '0);
    chki("rst_busy", int'(busy), 0);
    chki("rst_done", int'(done), 0);
    chki("rst_mul_start", int'(mul_start), 0);
    rst_b = 1'b1;

    run_op(W'(8'h5A), 16'd0, 0);
    run_op(W'(2), 16'd1, 0);
    run_op(W'(2), 16'd2, 0);
    run_op(W'(2), 16'd107, 0);
    chk("x107_reduced", result, W'(12'h291));

    @(negedge clk);
    stray     = 1'b1;
    stray_val = rnd_el();
    @(negedge clk);
    stray = 1'b0;
    #1;
    chk("stray_idle_result", result, W'(12'h291));
    chki("stray_idle_busy", int'(busy), 0);

    run_op(W'(2), 16'd3, 50);
    chk("restart_ignored", result, W'(8));

    @(negedge clk);
    start = 1'b1;
    base  = W'(2);
    exp   = 16'h00F5;
    s     = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 5) @(negedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    chk("abort_result", result, '0);
    chki("abort_busy", int'(busy), 0);
    chki("abort_done", int'(done), 0);
    chki("abort_mul_start", int'(mul_start), 0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    repeat (20) @(negedge clk);
    run_op(W'(2), 16'd1, 0);

    run_op(W'(1), 16'hFFFF, 0);

    for (int i = 0; i < 100; i++) begin
      b = rnd_el();
      e = E'($urandom);
      if (i % 25 == 3) b = '0;
      if (i % 25 == 7) e = '0;
      run_op(b, e, 0);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gf2m_pow_ctrl.md
# gf2m_pow_ctrl

Sequencing controller for exponentiation in GF(2^m) over the pentanomial field f(x) = x^WIDTH + x^k3 + x^k2 + x^k1 + 1. It computes result = base^exp mod f(x) with left-to-right square-and-multiply. It sits directly upstream of the digit-serial GF(2^m) multiplier: it issues start/operand pairs to the multiplier and consumes the multiplier's done/product. It serves as the building block for Itoh–Tsujii-style inversion and other power maps in the ROLLO datapath.

## Interface
Parameters:
- WIDTH, 107: field degree m. Width of base, result and multiplier operands.
- EXP_W, 16: exponent width in bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_b  in  1  reset. Asynchronous and active-low: assertion clears all state immediately, independent of clk.
- start  in  1  one-cycle request. Sampled only in IDLE.
- base  in  WIDTH  field element. Latched when start is accepted.
- exp  in  EXP_W  exponent. Latched when start is accepted.
- busy  out  1  high from the cycle after start is accepted through the FIN cycle.
- done  out  1  one-cycle pulse in FIN. result is valid from this cycle.
- result  out  WIDTH  accumulator. Held until the next accepted start.
- mul_start  out  1  one-cycle pulse to the multiplier's start.
- mul_op_a  out  WIDTH  multiplier operand a. Equals acc.
- mul_op_b  out  WIDTH  multiplier operand b. Equals acc in a square, base_r in a multiply.
- mul_done  in  1  multiplier completion pulse.
- mul_op_c  in  WIDTH  multiplier product. Valid while mul_done=1.

## Operation
- Registers:
  - acc[WIDTH]: the accumulator, driven on result.
  - base_r[WIDTH] and exp_r[EXP_W]: latched operands.
  - idx[clog2(EXP_W)]: exponent bit index.
  - state: one of IDLE, SQ, SQ_W, MUL, MUL_W, FIN.
- IDLE:
  - On start: base_r←base, exp_r←exp, acc←1 (bit 0 set), idx←EXP_W-1, go to SQ.
  - Otherwise stay in IDLE. acc is unchanged.
- SQ: mul_start=1, mul_op_a=mul_op_b=acc. Go to SQ_W.
- SQ_W: wait for mul_done. On mul_done, acc←mul_op_c, then:
  - if exp_r[idx]=1, go to MUL;
  - else if idx=0, go to FIN;
  - else idx←idx-1 and go to SQ.
- MUL: mul_start=1, mul_op_a=acc, mul_op_b=base_r. Go to MUL_W.
- MUL_W: on mul_done, acc←mul_op_c, then:
  - if idx=0, go to FIN;
  - else idx←idx-1 and go to SQ.
- FIN: done=1. Go to IDLE.
- Leading zero bits of the exponent are not skipped. Every run performs exactly EXP_W squarings plus popcount(exp) multiplies, so N_ops = EXP_W + popcount(exp).
- exp=0 yields result=1 for any base, including base=0.
- start outside IDLE (busy=1 or FIN) is ignored. The latched operands are not disturbed.
- mul_done outside SQ_W/MUL_W is ignored. It produces no acc update.
- mul_start is a Moore output from state, so it is glitch-free and exactly one cycle per operation. The controller never issues a second mul_start before the matching mul_done.
- Reset values: state=IDLE, acc=0 (result=0), base_r=0, exp_r=0, idx=0, busy=0, done=0, mul_start=0.
- Reset mid-operation aborts the run; no done is produced. The multiplier shares the reset net.

## Timing
- Let the multiplier return mul_done L cycles after the mul_start cycle. For the team digit-serial multiplier, L = DIGIT_N+1, where DIGIT_N = WIDTH/d + 1. With WIDTH=107 and d=16, L=8.
- Cycle numbering:
  - start is sampled high at the end of cycle 0.
  - The first mul_start is in cycle 1.
  - Each operation occupies L+1 cycles: the issue cycle plus L wait cycles, with the product captured at the end of the mul_done cycle.
- done is high in cycle 1 + N_ops·(L+1). busy is low again the cycle after that.
- A new start is accepted in the first IDLE cycle after FIN, so back-to-back runs are possible.
- Product capture and the next issue never share a cycle.

## Test plan
All scenarios use WIDTH=107, k3=9, k2=7, k1=4, EXP_W=16, against the real multiplier (L=8).
- base=0x5A, exp=0 -> result=1; done in cycle 145 (16 ops); exactly 16 mul_start pulses, all squares.
- base=x (0x2), exp=1 -> result=0x2; done in cycle 154 (17 ops). base=x, exp=2 -> result=0x4.
- base=x, exp=107 (0x006B, popcount 5) -> result=x^9+x^7+x^4+1=0x291; done in cycle 190 (21 ops). This exercises the reduction path.
- start pulsed again in cycle 50 of a run with exp=3, base=x, plus a stray mul_done in IDLE -> both ignored; result=0x8; done timing is unchanged.
- rst_b dropped asynchronously mid-way through SQ_W -> all outputs at their reset values immediately, no done pulse; a fresh start with exp=1, base=x after release -> result=0x2.
- exp=0xFFFF, base=1 -> result=1; 32 ops; done in cycle 289. Compare against a software model on 100 random (base, exp) pairs for exact result match.
